// File: rtl/mul4_vec_pkg.sv
// mul4_vec_pkg: shared constants and state encoding for the mul4_vector
// divider slice.
//   LANES_DEF : default number of bit-sliced lanes (width of every plane)
//   STEP_W    : width of the restoring-division step counter
//   DVD_W / DVS_W / REM_W : per-lane dividend / divisor / partial-remainder widths
//   state_t   : controller states, encoded with the legacy localparam values
package mul4_vec_pkg;

    localparam int unsigned LANES_DEF = 16;
    localparam int unsigned STEP_W    = 2;
    localparam int unsigned DVD_W     = 4;
    localparam int unsigned DVS_W     = 2;
    localparam int unsigned REM_W     = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/mul4_div_step.sv
// mul4_div_step: one combinational restoring-division step across all lanes.
//   rem1, rem0   : current partial-remainder planes (low two bits)
//   dbit         : dividend bit plane brought down this step
//   b1, b0       : divisor planes
//   nrem1, nrem0 : partial-remainder planes after the step
//   qbit         : quotient bit plane produced by the step
// The trial value is 3 bits, but after a subtract it is always below the
// divisor (<= 2), so only the low two bits are carried between steps.
// Zero-divisor lanes lose bit 2 here, exactly as the {rem[1:0], d} shift
// would; their results are overridden by the controller anyway.
module mul4_div_step
    import mul4_vec_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF
) (
    input  logic [LANES-1:0] rem1,
    input  logic [LANES-1:0] rem0,
    input  logic [LANES-1:0] dbit,
    input  logic [LANES-1:0] b1,
    input  logic [LANES-1:0] b0,
    output logic [LANES-1:0] nrem1,
    output logic [LANES-1:0] nrem0,
    output logic [LANES-1:0] qbit
);

    logic [REM_W-1:0] sh;
    logic [REM_W-1:0] dv;
    logic [REM_W-1:0] t;

    always_comb begin
        nrem1 = '0;
        nrem0 = '0;
        qbit  = '0;
        sh    = '0;
        dv    = '0;
        t     = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sh = {rem1[i], rem0[i], dbit[i]};
            dv = {1'b0, b1[i], b0[i]};
            if (sh >= dv) begin
                t       = sh - dv;
                qbit[i] = 1'b1;
            end else begin
                t       = sh;
                qbit[i] = 1'b0;
            end
            nrem1[i] = t[1];
            nrem0[i] = t[0];
        end
    end

endmodule

// File: rtl/mul4_vector_div.sv
// mul4_vector_div: bit-sliced sequential restoring divider (4-bit / 2-bit per
// lane), the inverse of the mul4_vector 2x2 multiply.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (d3..d0 dividend, b1,b0 divisor)
//   out_valid / out_ready : result handshake (q3..q0 quotient, r1,r0 remainder)
//   dz                    : per-lane divide-by-zero flag (q=15, r=d[1:0])
//   chk_err               : only with MUL4_DIV_CHECK_EN defined; per-lane
//                           q*b+r==d / r<b self-check, valid with out_valid
// Operand accepted at edge k: CALC steps on edges k+1..k+4, the result
// registers load on edge k+5 (first DONE cycle) and out_valid rises there.
module mul4_vector_div
    import mul4_vec_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] d3,
    input  logic [LANES-1:0] d2,
    input  logic [LANES-1:0] d1,
    input  logic [LANES-1:0] d0,
    input  logic [LANES-1:0] b1,
    input  logic [LANES-1:0] b0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] q3,
    output logic [LANES-1:0] q2,
    output logic [LANES-1:0] q1,
    output logic [LANES-1:0] q0,
    output logic [LANES-1:0] r1,
    output logic [LANES-1:0] r0,
    output logic [LANES-1:0] dz
`ifdef MUL4_DIV_CHECK_EN
    ,
    output logic [LANES-1:0] chk_err
`endif
);

    state_t              state;
    logic [STEP_W-1:0]   step;
    logic [LANES-1:0]    dr3, dr2, dr1, dr0;
    logic [LANES-1:0]    br1, br0;
    logic [LANES-1:0]    rm1, rm0;
    logic [LANES-1:0]    qr3, qr2, qr1, qr0;
    logic [LANES-1:0]    dbit, qbit, nrem1, nrem0, dzv;

    assign in_ready = (state == IDLE);
    assign dzv      = ~(br1 | br0);

    always_comb begin
        dbit = '0;
        case (step)
            2'd3:    dbit = dr3;
            2'd2:    dbit = dr2;
            2'd1:    dbit = dr1;
            default: dbit = dr0;
        endcase
    end

    mul4_div_step #(.LANES(LANES)) u_step (
        .rem1  (rm1),
        .rem0  (rm0),
        .dbit  (dbit),
        .b1    (br1),
        .b0    (br0),
        .nrem1 (nrem1),
        .nrem0 (nrem0),
        .qbit  (qbit)
    );

`ifdef MUL4_DIV_CHECK_EN
    logic [LANES-1:0]  chk_v;
    logic [DVD_W-1:0]  cq, cd;
    logic [DVS_W-1:0]  cb, cr;
    logic [5:0]        prod;

    always_comb begin
        chk_v = '0;
        cq    = '0;
        cd    = '0;
        cb    = '0;
        cr    = '0;
        prod  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            cq   = {qr3[i], qr2[i], qr1[i], qr0[i]};
            cd   = {dr3[i], dr2[i], dr1[i], dr0[i]};
            cb   = {br1[i], br0[i]};
            cr   = {rm1[i], rm0[i]};
            prod = {2'b00, cq} * {4'b0000, cb} + {4'b0000, cr};
            chk_v[i] = !dzv[i] && ((prod != {2'b00, cd}) || (cr >= cb));
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step      <= '0;
            {dr3, dr2, dr1, dr0} <= '0;
            {br1, br0} <= '0;
            {rm1, rm0} <= '0;
            {qr3, qr2, qr1, qr0} <= '0;
            out_valid <= 1'b0;
            {q3, q2, q1, q0} <= '0;
            {r1, r0}  <= '0;
            dz        <= '0;
`ifdef MUL4_DIV_CHECK_EN
            chk_err   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        {dr3, dr2, dr1, dr0} <= {d3, d2, d1, d0};
                        {br1, br0} <= {b1, b0};
                        {rm1, rm0} <= '0;
                        {qr3, qr2, qr1, qr0} <= '0;
                        step  <= 2'd3;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rm1 <= nrem1;
                    rm0 <= nrem0;
                    case (step)
                        2'd3:    qr3 <= qbit;
                        2'd2:    qr2 <= qbit;
                        2'd1:    qr1 <= qbit;
                        default: qr0 <= qbit;
                    endcase
                    step <= step - 1'b1;
                    if (step == 2'd0) state <= DONE;
                end
                DONE: begin
                    // First DONE cycle loads the result registers; out_ready
                    // is only honoured once out_valid is already high.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        q3 <= qr3 | dzv;
                        q2 <= qr2 | dzv;
                        q1 <= qr1 | dzv;
                        q0 <= qr0 | dzv;
                        r1 <= (dzv & dr1) | (~dzv & rm1);
                        r0 <= (dzv & dr0) | (~dzv & rm0);
                        dz <= dzv;
`ifdef MUL4_DIV_CHECK_EN
                        chk_err <= chk_v;
`endif
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
`ifdef MUL4_DIV_CHECK_EN
                        chk_err   <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul4_vector_div.sv
module tb_mul4_vector_div;

    localparam int unsigned L = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid;
    logic [L-1:0] d3 = '0, d2 = '0, d1 = '0, d0 = '0, b1 = '0, b0 = '0;
    logic [L-1:0] q3, q2, q1, q0, r1, r0, dz;
`ifdef MUL4_DIV_CHECK_EN
    logic [L-1:0] chk_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [L-1:0][3:0] d;
        logic [L-1:0][1:0] b;
        logic [L-1:0][3:0] q;
        logic [L-1:0][1:0] r;
        logic [L-1:0]      dz;
    } vec_t;

    vec_t tbl [8];
    vec_t sb [$];

    mul4_vector_div #(.LANES(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d3        (d3),
        .d2        (d2),
        .d1        (d1),
        .d0        (d0),
        .b1        (b1),
        .b0        (b0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q3        (q3),
        .q2        (q2),
        .q1        (q1),
        .q0        (q0),
        .r1        (r1),
        .r0        (r0),
        .dz        (dz)
`ifdef MUL4_DIV_CHECK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer divide, zero divisor -> q=15, r=d[1:0].
    function automatic vec_t model(input vec_t v);
        vec_t o;
        int dv, bv;
        o = v;
        for (int i = 0; i < L; i++) begin
            dv = int'(v.d[i]);
            bv = int'(v.b[i]);
            if (bv == 0) begin
                o.q[i]  = 4'hF;
                o.r[i]  = 2'(dv % 4);
                o.dz[i] = 1'b1;
            end else begin
                o.q[i]  = 4'(dv / bv);
                o.r[i]  = 2'(dv % bv);
                o.dz[i] = 1'b0;
            end
        end
        return o;
    endfunction

    function automatic logic [63:0] qplanes(input vec_t v);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < L; i++) begin
            p[48+i] = v.q[i][3];
            p[32+i] = v.q[i][2];
            p[16+i] = v.q[i][1];
            p[i]    = v.q[i][0];
        end
        return p;
    endfunction

    function automatic logic [31:0] rplanes(input vec_t v);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < L; i++) begin
            p[16+i] = v.r[i][1];
            p[i]    = v.r[i][0];
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        for (int i = 0; i < L; i++) begin
            d3[i] = v.d[i][3];
            d2[i] = v.d[i][2];
            d1[i] = v.d[i][1];
            d0[i] = v.d[i][0];
            b1[i] = v.b[i][1];
            b0[i] = v.b[i][0];
        end
    endtask

    // Called #1 after a clock edge with the DUT idle.
    task automatic do_op(input vec_t v, input int hold);
        int lat;
        vec_t e;
        vec_t junk;
        logic [111:0] snap;
        check("in_ready_idle", 128'(in_ready), 128'(1));
        drive(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(model(v));
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 128'(lat), 128'(5));
        if (!out_valid) return;
        e = sb.pop_front();
        check("q_planes", 128'({q3, q2, q1, q0}), 128'(qplanes(e)));
        check("r_planes", 128'({r1, r0}), 128'(rplanes(e)));
        check("dz", 128'(dz), 128'(e.dz));
`ifdef MUL4_DIV_CHECK_EN
        check("chk_err_clean", 128'(chk_err), 128'(0));
`endif
        snap = {q3, q2, q1, q0, r1, r0, dz};
        if (hold > 0) begin
            junk = '0;
            for (int i = 0; i < L; i++) begin
                junk.d[i] = 4'($urandom_range(15, 0));
                junk.b[i] = 2'($urandom_range(3, 1));
            end
            drive(junk);
            in_valid = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                check("bp_hold", 128'({out_valid, in_ready, q3, q2, q1, q0, r1, r0, dz}),
                      128'({1'b1, 1'b0, snap}));
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release", 128'({out_valid, in_ready}), 128'(2'b01));
        check("idle_hold", 128'({q3, q2, q1, q0, r1, r0, dz}), 128'(snap));
`ifdef MUL4_DIV_CHECK_EN
        check("chk_err_cleared", 128'(chk_err), 128'(0));
`endif
    endtask

    initial begin
        int p;
        int seen;
        logic [63:0] qp;
        logic [15:0] fq0;

        // Vector table: inputs here, expected outputs from the model.
        for (int k = 0; k < 8; k++) tbl[k] = '0;
        for (int i = 0; i < L; i++) begin
            tbl[0].d[i] = 4'd0;  tbl[0].b[i] = 2'd2;
            tbl[1].d[i] = 4'd6;  tbl[1].b[i] = 2'd2;
        end
        tbl[0].d[0] = 4'd13; tbl[0].b[0] = 2'd3;
        tbl[0].d[1] = 4'd15; tbl[0].b[1] = 2'd1;
        tbl[1].b[2] = 2'd0;
        for (int k = 2; k < 6; k++) begin
            for (int i = 0; i < L; i++) begin
                p = (k - 2) * 16 + i;
                tbl[k].d[i] = 4'(p / 4);
                tbl[k].b[i] = 2'(p % 4);
            end
        end
        for (int k = 6; k < 8; k++) begin
            for (int i = 0; i < L; i++) begin
                tbl[k].d[i] = 4'($urandom_range(15, 0));
                tbl[k].b[i] = 2'($urandom_range(3, 0));
            end
        end
        for (int k = 0; k < 8; k++) tbl[k] = model(tbl[k]);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 128'({in_ready, out_valid, q3, q2, q1, q0, r1, r0, dz}),
              128'({1'b1, 1'b0, 112'b0}));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases and the exhaustive 64-pair sweep.
        for (int k = 0; k < 6; k++) do_op(tbl[k], 0);

        // Backpressure: out_ready low for 10 cycles with a new in_valid pending.
        do_op(tbl[7], 10);

        // Reset during the second CALC cycle.
        drive(tbl[6]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        check("reset_mid_calc", 128'({out_valid, in_ready, q3, q2, q1, q0, r1, r0, dz}),
              128'({1'b0, 1'b1, 112'b0}));
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("no_stale_result", 128'(seen), 128'(0));
        do_op(tbl[6], 0);

`ifdef MUL4_DIV_CHECK_EN
        // Corrupt lane 5's quotient after the last step, before the result loads.
        drive(tbl[0]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        qp  = qplanes(tbl[0]);
        fq0 = qp[15:0] ^ 16'h0020;
        force dut.qr0 = fq0;
        @(posedge clk); #1;
        release dut.qr0;
        check("chk_force_valid", 128'(out_valid), 128'(1));
        check("chk_force", 128'(chk_err), 128'(16'h0020));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("chk_force_cleared", 128'(chk_err), 128'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
